ddr_read_arbiter: RTL and testbench

DDR_READ_ARBITER -- requirements
Module: ddr_read_arbiter

---
 rtl/ddr_read_arbiter_pkg.sv | 24 ++
 rtl/ddr_tag_fifo.sv | 79 +++++++
 rtl/ddr_read_arbiter.sv | 140 ++++++++++++++
 tb/tb_ddr_read_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_read_arbiter_pkg.sv
// Shared types for the two-requester DDR read arbiter.
// Latency: none (types and helpers only).
// Backpressure: not applicable.
//
// Holds the arbiter FSM encoding and the requester-ID type. The ID type is
// also the tag width stored per outstanding read.
package ddr_read_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_e;

    // Requester identifier: 0 = m0, 1 = m1.
    typedef logic req_id_t;

    localparam int unsigned REQ_ID_W = 1;

    // Identifier of the requester that is not `id`.
    function automatic req_id_t other_req(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/ddr_tag_fifo.sv
// Tag FIFO remembering which requester owns each outstanding DDR read.
// Latency: push visible at the head one cycle later; head is combinational.
// Backpressure: push while full and pop while empty are ignored.
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   push, push_dat      write one tag
//   pop                 retire the head tag
//   head_dat            oldest stored tag
//   empty, full, count  occupancy (count is 0..DEPTH)
module ddr_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/ddr_read_arbiter.sv
// Round-robin arbiter sharing one DDR3 Avalon-MM read port between two requesters.
// Latency: one IDLE cycle then the ISSUE cycle per read; return path is combinational.
// Backpressure: ddr_waitrequest stalls the granted requester; a full tag FIFO stalls both.
//
// Ports:
//   clk, rst                       rising-edge clock, async active-high reset
//   m0_*/m1_*                      requester Avalon-MM read ports
//   ddr_*                          shared DDR3 read port
//   pending                        outstanding-read count (0..DEPTH)
//   err_orphan                     sticky: data returned with nothing outstanding
module ddr_read_arbiter
    import ddr_read_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         m0_addr,
    input  logic                      m0_read,
    output logic                      m0_waitrequest,
    output logic signed [DATA_W-1:0]  m0_readdata,
    output logic                      m0_readdatavalid,
    input  logic [ADDR_W-1:0]         m1_addr,
    input  logic                      m1_read,
    output logic                      m1_waitrequest,
    output logic signed [DATA_W-1:0]  m1_readdata,
    output logic                      m1_readdatavalid,
    output logic [ADDR_W-1:0]         ddr_addr,
    output logic                      ddr_read,
    input  logic                      ddr_waitrequest,
    input  logic signed [DATA_W-1:0]  ddr_readdata,
    input  logic                      ddr_readdatavalid,
    output logic [$clog2(DEPTH):0]    pending,
    output logic                      err_orphan
);

    arb_state_e state_q, state_d;
    req_id_t    grant_q, grant_d;
    req_id_t    rr_ptr_q, rr_ptr_d;
    logic       err_orphan_q, err_orphan_d;

    logic       gnt_read;
    logic       fav_read;
    logic       tag_push;
    logic       tag_pop;
    req_id_t    tag_head;
    logic       tag_empty;
    logic       tag_full;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    assign gnt_read = grant_q  ? m1_read : m0_read;
    assign fav_read = rr_ptr_q ? m1_read : m0_read;

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_ptr_d       = rr_ptr_q;
        tag_push       = 1'b0;
        ddr_read       = 1'b0;
        ddr_addr       = grant_q ? m1_addr : m0_addr;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                // Uses the registered occupancy: a pop this cycle only
                // frees a slot for the grant decision of the next cycle.
                if ((m0_read || m1_read) && !tag_full) begin
                    state_d = ST_ISSUE;
                    grant_d = fav_read ? rr_ptr_q : other_req(rr_ptr_q);
                end
            end
            ST_ISSUE: begin
                ddr_read = gnt_read;
                if (grant_q) begin
                    m1_waitrequest = ddr_waitrequest;
                end else begin
                    m0_waitrequest = ddr_waitrequest;
                end
                if (!gnt_read) begin
                    // Requester withdrew: drop the slot, keep its priority.
                    state_d = ST_IDLE;
                end else if (!ddr_waitrequest) begin
                    tag_push = 1'b1;
                    rr_ptr_d = other_req(grant_q);
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Return side: the head tag names the owner of the next return
    // ------------------------------------------------------------------
    assign tag_pop          = ddr_readdatavalid & ~tag_empty;
    assign m0_readdata      = ddr_readdata;
    assign m1_readdata      = ddr_readdata;
    assign m0_readdatavalid = tag_pop & (tag_head == 1'b0);
    assign m1_readdatavalid = tag_pop & (tag_head == 1'b1);

    assign err_orphan_d = err_orphan_q | (ddr_readdatavalid & tag_empty);
    assign err_orphan   = err_orphan_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            rr_ptr_q     <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    ddr_tag_fifo #(
        .WIDTH (REQ_ID_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tag_push),
        .push_dat (grant_q),
        .pop      (tag_pop),
        .head_dat (tag_head),
        .empty    (tag_empty),
        .full     (tag_full),
        .count    (pending)
    );

endmodule

// File: tb/tb_ddr_read_arbiter.sv
module tb_ddr_read_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [ADDR_W-1:0]        m0_addr, m1_addr;
    logic                     m0_read, m1_read;
    logic                     m0_waitrequest, m1_waitrequest;
    logic signed [DATA_W-1:0] m0_readdata, m1_readdata;
    logic                     m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0]        ddr_addr;
    logic                     ddr_read;
    logic                     ddr_waitrequest;
    logic signed [DATA_W-1:0] ddr_readdata;
    logic                     ddr_readdatavalid;
    logic [$clog2(DEPTH):0]   pending;
    logic                     err_orphan;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ddr_read_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .m0_addr           (m0_addr),
        .m0_read           (m0_read),
        .m0_waitrequest    (m0_waitrequest),
        .m0_readdata       (m0_readdata),
        .m0_readdatavalid  (m0_readdatavalid),
        .m1_addr           (m1_addr),
        .m1_read           (m1_read),
        .m1_waitrequest    (m1_waitrequest),
        .m1_readdata       (m1_readdata),
        .m1_readdatavalid  (m1_readdatavalid),
        .ddr_addr          (ddr_addr),
        .ddr_read          (ddr_read),
        .ddr_waitrequest   (ddr_waitrequest),
        .ddr_readdata      (ddr_readdata),
        .ddr_readdatavalid (ddr_readdatavalid),
        .pending           (pending),
        .err_orphan        (err_orphan)
    );

    // Stimulus only: hold reset for two cycles with idle inputs, release on a negedge.
    task automatic do_reset();
        rst = 1'b1;
        m0_addr = '0; m1_addr = '0; m0_read = 1'b0; m1_read = 1'b0;
        ddr_waitrequest = 1'b0; ddr_readdata = '0; ddr_readdatavalid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Stimulus only: run n cycles with current inputs, counting DDR acceptances.
    task automatic run_cycles(input int n, output int acc);
        acc = 0;
        repeat (n) begin
            #1;
            if (ddr_read && !ddr_waitrequest) acc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0_addr = '0; m1_addr = '0; m0_read = 1'b1; m1_read = 1'b1;
        ddr_waitrequest = 1'b0; ddr_readdata = 16'sh0055; ddr_readdatavalid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (ddr_read !== 1'b0) begin n_fail++; $display("FAIL rst_ddr_read: got %b want 0", ddr_read); end
        n_checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin n_fail++; $display("FAIL rst_waitreq: got %b want 11", {m0_waitrequest, m1_waitrequest}); end
        n_checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin n_fail++; $display("FAIL rst_rdv: got %b want 00", {m0_readdatavalid, m1_readdatavalid}); end
        n_checks++; if (pending !== 4'd0) begin n_fail++; $display("FAIL rst_pending: got %0d want 0", pending); end
        n_checks++; if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL rst_err_orphan: got %b want 0", err_orphan); end
        m0_read = 1'b0; m1_read = 1'b0; ddr_readdatavalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if ({ddr_read, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid} !== 5'b01100)
            begin n_fail++; $display("FAIL post_rst_outputs: got %b want 01100", {ddr_read, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid}); end
        @(negedge clk);
    endtask

    task automatic test_single_read();
        do_reset();
        m0_addr = 32'h100; m0_read = 1'b1;
        #1;
        n_checks++; if (m0_waitrequest !== 1'b1) begin n_fail++; $display("FAIL single_idle_wait: got %b want 1", m0_waitrequest); end
        @(negedge clk); #1;
        n_checks++; if (ddr_read !== 1'b1 || ddr_addr !== 32'h100) begin n_fail++; $display("FAIL single_issue: got read=%b addr=%h want 1/00000100", ddr_read, ddr_addr); end
        n_checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin n_fail++; $display("FAIL single_waitreq: got %b want 01", {m0_waitrequest, m1_waitrequest}); end
        @(negedge clk);
        m0_read = 1'b0;
        #1;
        n_checks++; if (pending !== 4'd1 || ddr_read !== 1'b0) begin n_fail++; $display("FAIL single_pending: got pend=%0d read=%b want 1/0", pending, ddr_read); end
        repeat (4) @(negedge clk);
        ddr_readdata = 16'sh1234; ddr_readdatavalid = 1'b1;
        #1;
        n_checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 16'sh1234) begin n_fail++; $display("FAIL single_return_m0: got v=%b d=%h want 1/1234", m0_readdatavalid, m0_readdata); end
        n_checks++; if (m1_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL single_return_m1: got %b want 0", m1_readdatavalid); end
        @(negedge clk);
        ddr_readdatavalid = 1'b0;
        #1;
        n_checks++; if (m0_readdatavalid !== 1'b0 || pending !== 4'd0 || err_orphan !== 1'b0) begin n_fail++; $display("FAIL single_after: got v=%b pend=%0d err=%b want 0/0/0", m0_readdatavalid, pending, err_orphan); end
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] seen [4];
        logic [ADDR_W-1:0] want [4];
        int cnt, first, last;
        logic e0;
        want[0] = 32'h200; want[1] = 32'h300; want[2] = 32'h200; want[3] = 32'h300;
        do_reset();
        m0_addr = 32'h200; m1_addr = 32'h300; m0_read = 1'b1; m1_read = 1'b1;
        cnt = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 20 && cnt < 4; cyc++) begin
            #1;
            if (ddr_read && !ddr_waitrequest) begin
                seen[cnt] = ddr_addr;
                if (cnt == 0) first = cyc;
                last = cyc;
                cnt++;
            end
            @(negedge clk);
        end
        m0_read = 1'b0; m1_read = 1'b0;
        n_checks++; if (cnt !== 4) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 4", cnt); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (seen[i] !== want[i]) begin n_fail++; $display("FAIL b2b_addr%0d: got %h want %h", i, seen[i], want[i]); end
        end
        n_checks++; if (last - first !== 6) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 6", last - first); end
        #1;
        n_checks++; if (pending !== 4'd4) begin n_fail++; $display("FAIL b2b_pending: got %0d want 4", pending); end
        for (int i = 0; i < 4; i++) begin
            e0 = (i % 2 == 0);
            ddr_readdata = 16'sh0A00 | 16'(i); ddr_readdatavalid = 1'b1;
            #1;
            n_checks++; if ({m0_readdatavalid, m1_readdatavalid} !== {e0, ~e0}) begin n_fail++; $display("FAIL b2b_route%0d: got %b want %b", i, {m0_readdatavalid, m1_readdatavalid}, {e0, ~e0}); end
            n_checks++; if ((e0 ? m0_readdata : m1_readdata) !== (16'sh0A00 | 16'(i))) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", i, e0 ? m0_readdata : m1_readdata, 16'h0A00 | 16'(i)); end
            @(negedge clk);
        end
        ddr_readdatavalid = 1'b0;
        #1;
        n_checks++; if (pending !== 4'd0) begin n_fail++; $display("FAIL b2b_drained: got %0d want 0", pending); end
    endtask

    task automatic test_full();
        int acc;
        do_reset();
        m0_addr = 32'h10; m1_addr = 32'h20; m0_read = 1'b1; m1_read = 1'b1;
        run_cycles(24, acc);
        #1;
        n_checks++; if (acc !== 8) begin n_fail++; $display("FAIL full_accepts: got %0d want 8", acc); end
        n_checks++; if (pending !== 4'd8) begin n_fail++; $display("FAIL full_pending: got %0d want 8", pending); end
        n_checks++; if ({m0_waitrequest, m1_waitrequest, ddr_read} !== 3'b110) begin n_fail++; $display("FAIL full_stall: got %b want 110", {m0_waitrequest, m1_waitrequest, ddr_read}); end
        ddr_readdata = 16'sh0F0F; ddr_readdatavalid = 1'b1;
        #1;
        n_checks++; if (m0_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL full_first_return: got %b want 1", m0_readdatavalid); end
        @(negedge clk);
        ddr_readdatavalid = 1'b0;
        #1;
        n_checks++; if (ddr_read !== 1'b0 || pending !== 4'd7) begin n_fail++; $display("FAIL full_pop_no_grant: got read=%b pend=%0d want 0/7", ddr_read, pending); end
        @(negedge clk); #1;
        n_checks++; if (ddr_read !== 1'b1 || m0_waitrequest !== 1'b0 || ddr_addr !== 32'h10) begin n_fail++; $display("FAIL full_ninth_issue: got read=%b wr0=%b addr=%h want 1/0/00000010", ddr_read, m0_waitrequest, ddr_addr); end
        @(negedge clk);
        m0_read = 1'b0; m1_read = 1'b0;
        #1;
        n_checks++; if (pending !== 4'd8) begin n_fail++; $display("FAIL full_ninth_accept: got %0d want 8", pending); end
    endtask

    task automatic test_ddr_stall();
        do_reset();
        ddr_waitrequest = 1'b1; m1_addr = 32'h4A0; m1_read = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (ddr_read !== 1'b1 || ddr_addr !== 32'h4A0) begin n_fail++; $display("FAIL stall_hold%0d: got read=%b addr=%h want 1/000004a0", i, ddr_read, ddr_addr); end
            n_checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11 || pending !== 4'd0) begin n_fail++; $display("FAIL stall_wait%0d: got wr=%b pend=%0d want 11/0", i, {m0_waitrequest, m1_waitrequest}, pending); end
            @(negedge clk);
        end
        ddr_waitrequest = 1'b0;
        #1;
        n_checks++; if (m1_waitrequest !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b want 0", m1_waitrequest); end
        @(negedge clk);
        m1_read = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (pending !== 4'd1) begin n_fail++; $display("FAIL stall_single_push: got %0d want 1", pending); end
        ddr_readdata = -16'sd5; ddr_readdatavalid = 1'b1;
        #1;
        n_checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b01 || m1_readdata !== -16'sd5) begin n_fail++; $display("FAIL stall_return: got %b d=%0d want 01/-5", {m0_readdatavalid, m1_readdatavalid}, m1_readdata); end
        @(negedge clk);
        ddr_readdatavalid = 1'b0;
    endtask

    task automatic test_abort();
        do_reset();
        ddr_waitrequest = 1'b1; m0_addr = 32'h50; m1_addr = 32'h60; m0_read = 1'b1;
        @(negedge clk);
        m0_read = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (pending !== 4'd0 || ddr_read !== 1'b0) begin n_fail++; $display("FAIL abort_no_push: got pend=%0d read=%b want 0/0", pending, ddr_read); end
        m0_read = 1'b1; m1_read = 1'b1; ddr_waitrequest = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (ddr_addr !== 32'h50 || m0_waitrequest !== 1'b0) begin n_fail++; $display("FAIL abort_rr_kept: got addr=%h wr0=%b want 00000050/0", ddr_addr, m0_waitrequest); end
        @(negedge clk);
        m0_read = 1'b0; m1_read = 1'b0;
    endtask

    task automatic test_orphan();
        do_reset();
        @(negedge clk);
        ddr_readdata = 16'sh7777; ddr_readdatavalid = 1'b1;
        #1;
        n_checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin n_fail++; $display("FAIL orphan_strobe: got %b want 00", {m0_readdatavalid, m1_readdatavalid}); end
        @(negedge clk);
        ddr_readdatavalid = 1'b0;
        #1;
        n_checks++; if (err_orphan !== 1'b1 || pending !== 4'd0) begin n_fail++; $display("FAIL orphan_flag: got err=%b pend=%0d want 1/0", err_orphan, pending); end
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (err_orphan !== 1'b1) begin n_fail++; $display("FAIL orphan_sticky: got %b want 1", err_orphan); end
    endtask

    task automatic test_reset_mid();
        int acc;
        do_reset();
        m0_addr = 32'h900; m0_read = 1'b1;
        run_cycles(6, acc);
        m0_read = 1'b0;
        #1;
        n_checks++; if (acc !== 3 || pending !== 4'd3) begin n_fail++; $display("FAIL mid_setup: got acc=%0d pend=%0d want 3/3", acc, pending); end
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if (pending !== 4'd0) begin n_fail++; $display("FAIL mid_async_clear: got %0d want 0", pending); end
        n_checks++; if ({ddr_read, m0_waitrequest, m1_waitrequest} !== 3'b011) begin n_fail++; $display("FAIL mid_rst_outputs: got %b want 011", {ddr_read, m0_waitrequest, m1_waitrequest}); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ddr_readdata = 16'sh0101; ddr_readdatavalid = 1'b1;
        #1;
        n_checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin n_fail++; $display("FAIL mid_late_strobe: got %b want 00", {m0_readdatavalid, m1_readdatavalid}); end
        @(negedge clk);
        ddr_readdatavalid = 1'b0;
        #1;
        n_checks++; if (err_orphan !== 1'b1) begin n_fail++; $display("FAIL mid_orphan: got %b want 1", err_orphan); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_full();
        test_ddr_stall();
        test_abort();
        test_orphan();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
